// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams W_0..W_63
// out of a 16-entry sliding window expanded with sigma0/sigma1.
module sha256_msg_schedule (
    input  logic        clock,
    input  logic        reset,
    input  logic        msg_valid,
    input  logic [31:0] msg_word,
    output logic        msg_ready,
    output logic        w_valid,
    output logic [31:0] w_word,
    output logic [5:0]  w_index,
    input  logic        w_ready,
    output logic        block_done
);

    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_e;

    state_e             state_q;
    logic [3:0]         load_cnt_q;
    logic [5:0]         emit_cnt_q;
    logic [15:0][31:0]  win_q, win_d;
    logic               block_done_q;

    logic               load_hs, emit_hs;
    logic [31:0]        w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load_hs = (state_q == LOAD) && msg_valid;
    assign emit_hs = (state_q == EMIT) && w_ready;

    // win_q[0] holds W_t; the new tail word is W_{t+16}
    assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        win_d = win_q;
        if (load_hs) begin
            win_d[load_cnt_q] = msg_word;
        end else if (emit_hs) begin
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = w_new;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            load_cnt_q   <= '0;
            emit_cnt_q   <= '0;
            win_q        <= '0;
            block_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            block_done_q <= emit_hs && (emit_cnt_q == 6'd63);
            case (state_q)
                LOAD: if (load_hs) begin
                    load_cnt_q <= load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_q    <= EMIT;
                        emit_cnt_q <= '0;
                    end
                end
                EMIT: if (emit_hs) begin
                    emit_cnt_q <= emit_cnt_q + 6'd1;
                    // words past W_63 are still shifted in but never presented
                    if (emit_cnt_q == 6'd63) begin
                        state_q    <= LOAD;
                        load_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign msg_ready  = (state_q == LOAD);
    assign w_valid    = (state_q == EMIT);
    assign w_word     = win_q[0];
    assign w_index    = emit_cnt_q;
    assign block_done = block_done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc", zero and single-bit blocks,
// with gaps, backpressure, ignored msg_valid and asynchronous reset.
module tb_sha256_msg_schedule;

    logic        clock, reset;
    logic        msg_valid, msg_ready;
    logic [31:0] msg_word;
    logic        w_valid, w_ready, block_done;
    logic [31:0] w_word;
    logic [5:0]  w_index;

    sha256_msg_schedule dut (
        .clock      (clock),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_word   (msg_word),
        .msg_ready  (msg_ready),
        .w_valid    (w_valid),
        .w_word     (w_word),
        .w_index    (w_index),
        .w_ready    (w_ready),
        .block_done (block_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          errs = 0, checks = 0, hs_total = 0;
    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // reference schedule straight from the FIPS 180-4 recurrence
    task automatic build_exp();
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_exp();
    endtask

    // called at a negedge; returns at the negedge after the n-th load handshake
    task automatic load_block(input int n, input bit gaps);
        int i = 0, cyc = 0;
        bit rdy;
        while (i < n && cyc < 400) begin
            chk("load_w_valid", w_valid, 1'b0);
            chk("load_msg_ready", msg_ready, 1'b1);
            if (cyc > 0) chk("load_block_done", block_done, 1'b0);
            rdy       = msg_ready;
            msg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            msg_word  = msg_valid ? blk[i] : $urandom;
            if (rdy && msg_valid) i++;
            cyc++;
            @(negedge clock);
        end
        if (i < n) chk("load_timeout", i, n);
        msg_valid = 1'b0;
    endtask

    // called at the negedge right after the last load handshake
    task automatic emit_block(input int n, input bit rnd_ready, input bit junk);
        int k = 0, cyc = 0;
        bit stalled = 0;
        logic [31:0] pw;
        logic [5:0]  pi;
        while (k < n && cyc < 1000) begin
            chk("w_valid", w_valid, 1'b1);
            chk("emit_msg_ready", msg_ready, 1'b0);
            chk("emit_block_done", block_done, 1'b0);
            if (stalled) begin
                chk("hold_word", w_word, pw);
                chk("hold_index", w_index, pi);
            end
            chk($sformatf("w_index@%0d", k), w_index, k);
            chk($sformatf("w_word[%0d]", k), w_word, exp_w[k]);
            got_w[k]  = w_word;
            w_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            msg_valid = junk;
            msg_word  = $urandom;
            stalled   = !w_ready;
            pw        = w_word;
            pi        = w_index;
            if (w_ready) begin
                k++;
                hs_total++;
            end
            cyc++;
            @(negedge clock);
        end
        if (k < n) chk("emit_timeout", k, n);
        w_ready   = 1'b0;
        msg_valid = 1'b0;
        if (n == 64) begin
            chk("block_done_pulse", block_done, 1'b1);
            chk("msg_ready_after_done", msg_ready, 1'b1);
            if (!rnd_ready) chk("emit_cycles", cyc, 64);
        end
    endtask

    // asserted mid-cycle so the check precedes the next clock edge
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_msg_ready", msg_ready, 1'b1);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_w_word", w_word, 32'h0);
        chk("rst_w_index", w_index, 6'd0);
        chk("rst_block_done", block_done, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int hs0;

    initial begin
        reset = 1'b0; msg_valid = 1'b0; msg_word = '0; w_ready = 1'b0;
        #1;
        chk("por_msg_ready", msg_ready, 1'b1);
        chk("por_w_valid", w_valid, 1'b0);
        chk("por_w_word", w_word, 32'h0);
        chk("por_w_index", w_index, 6'd0);
        chk("por_block_done", block_done, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // "abc" at full rate, with hand-computed spot values
        set_abc();
        load_block(16, 0);
        emit_block(64, 0, 0);
        chk("abc_W0", got_w[0], 32'h61626380);
        chk("abc_W15", got_w[15], 32'h00000018);
        chk("abc_W16", got_w[16], 32'h61626380);
        chk("abc_W17", got_w[17], 32'h000F0000);
        chk("abc_W63", got_w[63], 32'h12B1EDEB);
        @(negedge clock);
        chk("done_one_cycle", block_done, 1'b0);

        // gaps on msg_valid, toggling w_ready
        load_block(16, 1);
        emit_block(64, 1, 0);
        chk("gap_W63", got_w[63], 32'h12B1EDEB);

        // back-to-back: second load starts in the block_done cycle
        hs0 = hs_total;
        load_block(16, 0);
        emit_block(64, 0, 0);
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        build_exp();
        load_block(16, 0);
        emit_block(64, 0, 0);
        chk("zero_W63", got_w[63], 32'h0);
        chk("b2b_handshakes", hs_total - hs0, 128);

        // msg_valid held with changing words during EMIT
        set_abc();
        load_block(16, 0);
        emit_block(64, 0, 1);
        chk("junk_W63", got_w[63], 32'h12B1EDEB);

        // reset mid-load, then mid-emit, then a fresh block
        load_block(7, 0);
        async_reset();
        load_block(16, 0);
        emit_block(20, 0, 0);
        chk("mid_emit_index", w_index, 6'd20);
        async_reset();
        load_block(16, 0);
        emit_block(64, 0, 0);
        chk("post_rst_W16", got_w[16], 32'h61626380);

        // single-word expansion
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[1] = 32'h00000001;
        build_exp();
        load_block(16, 0);
        emit_block(64, 1, 0);
        chk("one_W16", got_w[16], 32'h02004000);
        chk("one_W17", got_w[17], 32'h00000001);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Producer side of the SHA-256 round datapath: accepts one 512-bit message block as sixteen 32-bit words over a valid/ready input stream. It then emits the 64 schedule words W_0..W_63, one per output handshake, to the round logic that consumes the hash vectors and choice/majority results. A 16-entry sliding window with the sigma0/sigma1 expansion produces W_16..W_63 on the fly. The window is reused for the next block once all 64 words have been accepted.

## Interface
- No parameters; word width fixed at 32, block length fixed at 16 words, schedule length fixed at 64.
- clock  input  1  100 MHz clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clock clock.
- msg_valid  input  1  msg_word carries a valid message word.
- msg_word  input  32  message word M_t, big-endian word order, M_0 first.
- msg_ready  output  1  block is in LOAD and accepts a word this cycle.
- w_valid  output  1  w_word/w_index hold a valid schedule word.
- w_word  output  32  schedule word W_t.
- w_index  output  6  t of the word on w_word, 0..63.
- w_ready  input  1  downstream accepts w_word this cycle.
- block_done  output  1  one-cycle pulse after W_63 is accepted.

## Operation
- Two-state FSM: LOAD, EMIT.
- LOAD:
  - msg_ready=1, w_valid=0.
  - A load handshake (msg_valid & msg_ready) writes msg_word into win[load_cnt] and increments the 4-bit load_cnt.
  - The handshake at load_cnt=15 moves the FSM to EMIT and clears emit_cnt to 0.
- EMIT:
  - msg_ready=0, w_valid=1, w_word=win[0], w_index=emit_cnt.
  - msg_valid is ignored.
- Emit handshake (w_valid & w_ready):
  - Shift the window: win[i] <= win[i+1] for i=0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32 with carries discarded.
  - Increment the 6-bit emit_cnt.
  - The shift also occurs for t>=48; those words are computed but never emitted.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- The emit handshake at emit_cnt=63 pulses block_done, returns the FSM to LOAD and clears load_cnt. Window contents are don't-care.
- Backpressure: while w_ready=0 in EMIT, w_word, w_index and window state hold stable.
- Reset values:
  - Asynchronous, any cycle, including mid-LOAD or mid-EMIT.
  - FSM=LOAD, load_cnt=0, emit_cnt=0, all win[]=0.
  - msg_ready=1 (combinational from state), w_valid=0, w_word=0, w_index=0, block_done=0.
  - A partially loaded or partially emitted block is discarded.

## Timing
- Outputs are functions of registered state only. There is no combinational path from msg_valid or w_ready to any output.
- Load: one word per cycle at full rate; 16 cycles minimum per block.
- Latency: the 16th load handshake at cycle N gives w_valid=1 with W_0 at cycle N+1.
- Emit: one word per cycle when w_ready is held high; W_63 is presented at N+64.
- block_done is high in the cycle after the W_63 handshake, which is also the first cycle of LOAD with msg_ready=1.
- Minimum block period is 80 cycles: 16 load plus 64 emit.
- A word presented in that same cycle can be accepted immediately.
- Counters never wrap silently:
  - load_cnt wraps 15->0 only on the LOAD->EMIT transition.
  - emit_cnt wraps 63->0 only on the EMIT->LOAD transition.

## Test plan
- "abc" block, M_0=0x61626380, M_1..M_14=0, M_15=0x00000018, w_ready held at 1:
  - W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000, W_63=0x12B1EDEB.
  - w_index runs 0..63 on consecutive cycles.
  - block_done pulses exactly once, at N+65.
- Random msg_valid gaps and w_ready toggling on "abc":
  - The same 64-word sequence is produced.
  - w_word/w_index are stable on every w_ready=0 cycle.
  - No msg_ready while in EMIT.
- Back-to-back blocks ("abc", then all-zero block):
  - The second block loads starting in the block_done cycle.
  - Second block gives W_0..W_63 all 0x00000000.
  - Exactly 128 emit handshakes total.
- msg_valid=1 held during the whole of EMIT with changing msg_word:
  - No effect on the emitted words.
  - msg_ready=0 throughout EMIT.
- Reset asserted after 7 load words, and again after 20 emitted words:
  - All outputs match reset values asynchronously (before the next clock edge).
  - A fresh "abc" block afterwards produces the correct W_16=0x61626380.
- Single-word expansion check with M_1=0x00000001, all other words 0:
  - W_16 = sigma0(1) = 0x02004000.
  - W_17 = 0x00000001 (W_1; all other terms are zero).
